// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encoding,
// FSM state type and width-generic two's-complement helpers.
package multdiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  // Helpers work on a fixed wide vector; callers zero-extend in and truncate out.
  localparam int MAXW = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic [MAXW-1:0] twos_neg(input logic [MAXW-1:0] v);
    return ~v + MAXW'(1);
  endfunction

  // Magnitude of a w-bit value; only negates when the op is signed.
  function automatic logic [MAXW-1:0] abs_val(input logic [MAXW-1:0] v,
                                              input logic [6:0]      w,
                                              input logic            is_signed);
    return (is_signed && v[w - 7'd1]) ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit producing HI/LO, one bit per cycle.
// Optional MULTDIV_EARLY_OUT_EN ends multiplies once the multiplier is exhausted.
module mult_div_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_t           state
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is sampled only while IDLE (busy=0); done pulses for one
  // cycle in DONE and hi/lo stay valid until the next result is written.

  state_t            state_next;
  logic [W2-1:0]     acc;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH:0]    rem;
  logic [CW-1:0]     cnt;
  logic              div_q;
  logic              res_neg;
  logic              rem_neg;

  logic              in_signed;
  logic              in_div;
  logic              in_div_zero;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic [WIDTH:0]    add_sum;
  logic [W2-1:0]     acc_step;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_sub;
  logic              div_ge;
  logic              cnt_last;
  logic              mul_exit;
  logic              run_exit;

  always_comb begin
    in_signed   = (op == OP_MULT) || (op == OP_DIV);
    in_div      = (op == OP_DIV) || (op == OP_DIVU);
    in_div_zero = in_div && (b == '0);
    mag_a       = WIDTH'(abs_val(MAXW'(a), 7'(WIDTH), in_signed));
    mag_b       = WIDTH'(abs_val(MAXW'(b), 7'(WIDTH), in_signed));

    add_sum  = {1'b0, acc[W2-1:WIDTH]} + (shreg[0] ? {1'b0, mcand} : '0);
    acc_step = {add_sum, acc[WIDTH-1:1]};

    // A set rem[WIDTH] means the shifted remainder already exceeds any divisor.
    div_shift = {rem[WIDTH-1:0], shreg[WIDTH-1]};
    div_ge    = rem[WIDTH] || (div_shift >= {1'b0, mcand});
    div_sub   = div_shift - {1'b0, mcand};

    cnt_last = (cnt == CW'(1));
`ifdef MULTDIV_EARLY_OUT_EN
    mul_exit = cnt_last || (shreg[WIDTH-1:1] == '0);
`else
    mul_exit = cnt_last;
`endif
    run_exit = div_q ? cnt_last : mul_exit;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = in_div_zero ? S_DONE : S_RUN;
      S_RUN:  if (run_exit) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      shreg    <= '0;
      rem      <= '0;
      cnt      <= '0;
      div_q    <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          div_q    <= in_div;
          mcand    <= in_div ? mag_b : mag_a;
          shreg    <= in_div ? mag_a : mag_b;
          res_neg  <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_neg  <= in_signed && a[WIDTH-1];
          div_zero <= in_div_zero;
          acc      <= '0;
          rem      <= '0;
          cnt      <= CW'(WIDTH);
        end
        S_RUN: begin
          cnt <= cnt - CW'(1);
          if (div_q) begin
            rem   <= div_ge ? div_sub : div_shift;
            shreg <= {shreg[WIDTH-2:0], div_ge};
          end else begin
            shreg <= shreg >> 1;
`ifdef MULTDIV_EARLY_OUT_EN
            // Skipped iterations would only shift right; do them in one go.
            acc <= mul_exit ? (acc_step >> (cnt - CW'(1))) : acc_step;
`else
            acc <= acc_step;
`endif
          end
        end
        S_FIX: begin
          if (div_q) begin
            lo <= res_neg ? WIDTH'(twos_neg(MAXW'(shreg))) : shreg;
            hi <= rem_neg ? WIDTH'(twos_neg(MAXW'(rem[WIDTH-1:0]))) : rem[WIDTH-1:0];
          end else begin
            {hi, lo} <= res_neg ? W2'(twos_neg(MAXW'(acc))) : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
